next_pc_ctrl: RTL and testbench
===============================

# next_pc_ctrl

Next-PC selection and fetch-control stage for the unicycle processor. It computes the next instruction address from the current program counter and the decoded control flow (sequential, branch, jump, halt). It drives the program counter's load value (`PCin`) and write enable (`PCWrite`). A small state machine sequences boot, run and halt/resume, and a saturating counter records retired instructions for debug.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction address width; must match the program counter width.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `Clock` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: reset, asynchronous, active-low.
- `PCout` input ADDR_W: current program counter value.
- `Branch` input 1: decoded conditional-branch instruction.
- `Zero` input 1: ALU zero flag; the branch is taken when `Branch` and `Zero` are both 1.
- `BranchOff` input ADDR_W: signed two's-complement branch offset.
- `Jump` input 1: decoded unconditional jump.
- `JumpAddr` input ADDR_W: absolute jump target.
- `Halt` input 1: decoded halt instruction.
- `Resume` input 1: external single-cycle pulse that leaves the halted state.
- `PCin` output ADDR_W: next PC value.
- `PCWrite` output 1: PC load enable.
- `Halted` output 1: 1 while in HALT.
- `Retired` output CNT_W: count of cycles with `PCWrite`=1.

## Operation
- FSM states are BOOT, RUN and HALT. State, `Halted` and `Retired` are registered. `PCin` and `PCWrite` are combinational from state and inputs.
- Arithmetic: seq = `PCout`+1 and br = `PCout`+1+`BranchOff`. Both are computed modulo 2^ADDR_W, so 0xFF+1 wraps to 0x00 and wrap is silent.
- Target priority in RUN is Halt > Jump > taken Branch > sequential.
- BOOT:
  - `PCWrite`=0 and `PCin`=0.
  - Always goes to RUN on the next edge.
- RUN:
  - If `Halt`=1: `PCWrite`=0 and next state is HALT.
  - Otherwise: `PCWrite`=1 and `PCin` is the selected target.
  - `Resume` is ignored in RUN.
- HALT:
  - If `Resume`=0: `PCWrite`=0, `PCin`=seq, and the state stays HALT.
  - If `Resume`=1: `PCWrite`=1 and `PCin`=seq, so execution continues after the halt instruction. Next state is RUN.
  - `Halt`, `Jump` and `Branch` are ignored in HALT.
- `Halted` is 1 exactly in the cycles where the state is HALT.
- `Retired` increments on every edge where `PCWrite`=1 and saturates at all-ones.
- Reset asserted at any time, including mid-HALT:
  - State goes immediately to BOOT.
  - `Retired`=0 and `Halted`=0.
  - `PCWrite`=0 and `PCin`=0 while held.

## Timing
- Reset values: `PCin`=0, `PCWrite`=0, `Halted`=0, `Retired`=0, state=BOOT.
- First edge after reset release is spent in BOOT with no PC write. The first PC load occurs in the following cycle.
- Zero-cycle latency from `Branch`/`Zero`/`Jump`/`Halt` to `PCin`/`PCWrite`. The PC captures the value on the same edge.
- Halt: in the cycle `Halt` is seen, `PCWrite` drops combinationally. `Halted` rises after that edge.
- Resume: the `Resume` cycle writes seq. `Halted` falls after that edge.
- `Resume` held high across several HALT cycles has the same effect as a single pulse, because the FSM is in RUN afterwards.
- Jump and taken branch in the same cycle: Jump wins.

## Structure
- Shared package/header holds the state encoding constants: BOOT=2'd0, RUN=2'd1, HALT=2'd2.
- Default widths ADDR_W=8 and CNT_W=16 also live there.
- One natural sub-module is `sat_counter`, a parameterised saturating counter with enable and async active-low clear, used for `Retired`.
- Target mux and adders stay inline.

## Test plan
- Reset/boot:
  - Stimulus: hold `Reset`=0, then release with `PCout`=0x00.
  - Required response: `PCWrite`=0 for one cycle (BOOT), then `PCWrite`=1 with `PCin`=0x01, and `Retired`=1 after that edge.
- Wrap:
  - Stimulus: in RUN with `PCout`=0xFF and no control inputs.
  - Required response: `PCin`=0x00.
- Branch:
  - Stimulus: `PCout`=0x10, `Branch`=1, `BranchOff`=0xFC (-4), with `Zero` toggled.
  - Required response: `PCin`=0x0D when `Zero`=1 and 0x11 when `Zero`=0.
- Priority:
  - Stimulus: `Jump`=1 with `JumpAddr`=0x40 plus a taken branch gives `PCin`=0x40.
  - Stimulus: add `Halt`=1 in the same cycle gives `PCWrite`=0, then `Halted`=1.
- Halt/resume:
  - Stimulus: `Halt` at `PCout`=0x22, then 5 idle cycles, then a `Resume` pulse.
  - Required response: `PCWrite`=0 for 6 cycles with `Retired` frozen. The `Resume` cycle gives `PCin`=0x23 with `PCWrite`=1, then `Halted`=0.
- Reset mid-HALT and saturation:
  - Stimulus: assert `Reset` asynchronously while in HALT.
  - Required response: `Halted`, `Retired` and `PCWrite` go to 0 before the next edge.
  - Stimulus: run with CNT_W=4 for 20 writes.
  - Required response: `Retired` stays at 0xF.

Source files
------------

// File: rtl/next_pc_ctrl_pkg.sv
// Shared constants for the next-PC / fetch-control stage.
// Holds the FSM state encoding and the default datapath widths.
package next_pc_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/next_pc_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/next_pc_ctrl.sv
// Next-PC selection and fetch control: boot/run/halt sequencing, target
// selection (halt > jump > taken branch > sequential) and retired-count.
module next_pc_ctrl
  import next_pc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PCout,
  input  logic              Branch,
  input  logic              Zero,
  input  logic [ADDR_W-1:0] BranchOff,
  input  logic              Jump,
  input  logic [ADDR_W-1:0] JumpAddr,
  input  logic              Halt,
  input  logic              Resume,
  output logic [ADDR_W-1:0] PCin,
  output logic              PCWrite,
  output logic              Halted,
  output logic [CNT_W-1:0]  Retired
);

  state_e            state_q;
  state_e            state_d;
  logic              halted_q;
  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] br_addr;

  // Both targets wrap silently modulo 2^ADDR_W.
  assign seq_addr = PCout + ADDR_W'(1);
  assign br_addr  = seq_addr + BranchOff;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= BOOT;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALT);
    end
  end

  // PCin/PCWrite are combinational so the PC captures the target on this edge.
  always_comb begin
    state_d = state_q;
    PCWrite = 1'b0;
    PCin    = '0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (Halt) begin
          state_d = HALT;
          PCin    = seq_addr;
        end else begin
          PCWrite = 1'b1;
          if (Jump) begin
            PCin = JumpAddr;
          end else if (Branch && Zero) begin
            PCin = br_addr;
          end else begin
            PCin = seq_addr;
          end
        end
      end
      HALT: begin
        PCin = seq_addr;
        if (Resume) begin
          PCWrite = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign Halted = halted_q;

  sat_counter #(
    .W(CNT_W)
  ) u_retired (
    .Clock(Clock),
    .Reset(Reset),
    .en   (PCWrite),
    .count(Retired)
  );

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Self-checking bench for next_pc_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_next_pc_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [7:0]  PCout = 8'h00;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic [7:0]  BranchOff = 8'h00;
  logic        Jump = 1'b0;
  logic [7:0]  JumpAddr = 8'h00;
  logic        Halt = 1'b0;
  logic        Resume = 1'b0;

  logic [7:0]  PCin;
  logic        PCWrite;
  logic        Halted;
  logic [15:0] Retired;
  logic [7:0]  PCin4;
  logic        PCWrite4;
  logic        Halted4;
  logic [3:0]  Retired4;

  int checks = 0;
  int failures = 0;

  // Behavioural model: boot flag, halted flag, retired counts.
  bit m_boot = 1'b1;
  bit m_halted = 1'b0;
  int m_ret = 0;
  int m_ret4 = 0;

  next_pc_ctrl #(.ADDR_W(8), .CNT_W(16)) u_dut (
    .Clock(Clock), .Reset(Reset), .PCout(PCout), .Branch(Branch), .Zero(Zero),
    .BranchOff(BranchOff), .Jump(Jump), .JumpAddr(JumpAddr), .Halt(Halt),
    .Resume(Resume), .PCin(PCin), .PCWrite(PCWrite), .Halted(Halted),
    .Retired(Retired)
  );

  next_pc_ctrl #(.ADDR_W(8), .CNT_W(4)) u_dut4 (
    .Clock(Clock), .Reset(Reset), .PCout(PCout), .Branch(Branch), .Zero(Zero),
    .BranchOff(BranchOff), .Jump(Jump), .JumpAddr(JumpAddr), .Halt(Halt),
    .Resume(Resume), .PCin(PCin4), .PCWrite(PCWrite4), .Halted(Halted4),
    .Retired(Retired4)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected combinational outputs for the current model state and inputs.
  function automatic void model_out(output logic w, output logic [7:0] pc, output logic v);
    logic [7:0] seq;
    seq = PCout + 8'd1;
    w = 1'b0; pc = 8'h00; v = 1'b1;
    if (!Reset || m_boot) begin
      w = 1'b0; pc = 8'h00;
    end else if (m_halted) begin
      w = Resume; pc = seq;
    end else if (Halt) begin
      w = 1'b0; v = 1'b0;
    end else begin
      w = 1'b1;
      if (Jump) pc = JumpAddr;
      else if (Branch && Zero) pc = seq + BranchOff;
      else pc = seq;
    end
  endfunction

  always @(posedge Clock or negedge Reset) begin
    logic w, v;
    logic [7:0] pc;
    if (!Reset) begin
      m_boot   <= 1'b1;
      m_halted <= 1'b0;
      m_ret    <= 0;
      m_ret4   <= 0;
    end else begin
      model_out(w, pc, v);
      if (w) begin
        m_ret  <= (m_ret  < 65535) ? m_ret + 1  : m_ret;
        m_ret4 <= (m_ret4 < 15)    ? m_ret4 + 1 : m_ret4;
      end
      if (m_boot) m_boot <= 1'b0;
      else if (m_halted) begin
        if (Resume) m_halted <= 1'b0;
      end else if (Halt) m_halted <= 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clock) begin
    logic w, v;
    logic [7:0] pc;
    model_out(w, pc, v);
    chk("pcwrite", 32'(PCWrite), 32'(w));
    chk("pcwrite4", 32'(PCWrite4), 32'(w));
    if (v) chk("pcin", 32'(PCin), 32'(pc));
    chk("halted", 32'(Halted), 32'(m_halted));
    chk("retired", 32'(Retired), 32'(m_ret));
    chk("retired4", 32'(Retired4), 32'(m_ret4));
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic idle();
    Branch = 1'b0; Zero = 1'b0; Jump = 1'b0; Halt = 1'b0; Resume = 1'b0;
    BranchOff = 8'h00; JumpAddr = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    // Reset and boot.
    repeat (3) tick();
    #1;
    chk("rst_pcwrite", 32'(PCWrite), 32'd0);
    chk("rst_pcin", 32'(PCin), 32'h00);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_retired", 32'(Retired), 32'd0);
    tick();
    Reset = 1'b1; PCout = 8'h00;
    #1 chk("boot_pcwrite", 32'(PCWrite), 32'd0);
    tick();
    #1 chk("first_pcwrite", 32'(PCWrite), 32'd1);
    chk("first_pcin", 32'(PCin), 32'h01);
    tick();
    #1 chk("first_retired", 32'(Retired), 32'd1);

    // Wrap.
    PCout = 8'hFF;
    #1 chk("wrap_pcin", 32'(PCin), 32'h00);

    // Branch with Zero toggled.
    tick();
    PCout = 8'h10; Branch = 1'b1; BranchOff = 8'hFC; Zero = 1'b1;
    #1 chk("br_taken", 32'(PCin), 32'h0D);
    tick();
    Zero = 1'b0;
    #1 chk("br_not_taken", 32'(PCin), 32'h11);

    // Priority: jump over branch, halt over jump.
    tick();
    Zero = 1'b1; Jump = 1'b1; JumpAddr = 8'h40;
    #1 chk("jump_wins", 32'(PCin), 32'h40);
    tick();
    Halt = 1'b1;
    #1 chk("halt_wins", 32'(PCWrite), 32'd0);
    tick();
    idle(); PCout = 8'h41;
    #1 chk("halted_rise", 32'(Halted), 32'd1);
    tick();
    Resume = 1'b1;
    #1 chk("resume_pcin", 32'(PCin), 32'h42);
    tick();
    Resume = 1'b0;
    #1 chk("halted_fall", 32'(Halted), 32'd0);

    // Halt, 5 idle cycles, resume.
    tick();
    PCout = 8'h22; Halt = 1'b1;
    #1 chk("hr_halt_pcwrite", 32'(PCWrite), 32'd0);
    r0 = m_ret;
    for (int i = 0; i < 5; i++) begin
      tick();
      Halt = 1'b0;
      #1 chk("hr_idle_pcwrite", 32'(PCWrite), 32'd0);
      chk("hr_idle_retired", 32'(Retired), 32'(r0));
    end
    tick();
    Resume = 1'b1;
    #1 chk("hr_resume_pcwrite", 32'(PCWrite), 32'd1);
    chk("hr_resume_pcin", 32'(PCin), 32'h23);
    tick();
    Resume = 1'b0;
    #1 chk("hr_halted_fall", 32'(Halted), 32'd0);
    chk("hr_retired", 32'(Retired), 32'(r0 + 1));

    // Asynchronous reset while halted.
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    #1 chk("mid_halted", 32'(Halted), 32'd1);
    tick();
    Reset = 1'b0;
    #1 chk("async_halted", 32'(Halted), 32'd0);
    chk("async_retired", 32'(Retired), 32'd0);
    chk("async_retired4", 32'(Retired4), 32'd0);
    chk("async_pcwrite", 32'(PCWrite), 32'd0);
    chk("async_pcin", 32'(PCin), 32'h00);
    tick();
    Reset = 1'b1;

    // Saturation of the narrow counter over 20 writes.
    for (int i = 0; i < 20; i++) begin
      tick();
      PCout = 8'(i);
    end
    tick();
    #1 chk("sat_retired4", 32'(Retired4), 32'hF);
    chk("sat_retired", 32'(Retired), 32'd20);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 2000; i++) begin
      tick();
      PCout     = 8'($urandom);
      Branch    = ($urandom % 3) == 0;
      Zero      = ($urandom % 2) == 0;
      BranchOff = 8'($urandom);
      Jump      = ($urandom % 5) == 0;
      JumpAddr  = 8'($urandom);
      Halt      = ($urandom % 12) == 0;
      Resume    = ($urandom % 4) == 0;
      if (!Reset) Reset = 1'b1;
      else if (($urandom % 150) == 0) Reset = 1'b0;
    end
    tick();
    idle();
    Reset = 1'b1;
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
